// File: rtl/fwd_fft_idx_pkg.sv
// Shared widths, FSM encoding and sideband payload for the forward-FFT
// butterfly index generator.
package fwd_fft_idx_pkg;

  localparam int unsigned LOG2N_MAX = 9;
  localparam int unsigned J_W       = 8;
  localparam int unsigned STRIDE_W  = 24;
  localparam int unsigned PROD_W    = 32;
  localparam int unsigned STAGE_W   = 4;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN
  } state_t;

  typedef struct packed {
    logic               valid;
    logic               last;
    logic [STAGE_W-1:0] stage;
    logic [J_W-1:0]     group;
    logic [J_W-1:0]     j;
  } sb_t;

endpackage

// File: rtl/fwd_fft_sideband_dly.sv
// ce-gated shift register that carries butterfly sideband alongside the
// twiddle multiplier pipeline; cleared synchronously on reset.
module fwd_fft_sideband_dly
  import fwd_fft_idx_pkg::*;
#(
  parameter int unsigned DEPTH = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic ce,
  input  sb_t  din,
  output sb_t  dout
);

  sb_t stage_q [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) stage_q[i] <= '0;
    end else if (ce) begin
      stage_q[0] <= din;
      for (int i = 1; i < int'(DEPTH); i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/fwd_fft_bfly_idx_gen.sv
// Walks every radix-2 butterfly of an N-point forward FFT, driving j and the
// twiddle stride into the exponent multiplier with an aligned sideband.
module fwd_fft_bfly_idx_gen
  import fwd_fft_idx_pkg::*;
#(
  parameter int unsigned LOG2N   = 9,
  parameter int unsigned MUL_LAT = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ce,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic [J_W-1:0]      mul_din0,
  output logic [STRIDE_W-1:0] mul_din1,
  output logic                out_valid,
  output logic [STAGE_W-1:0]  out_stage,
  output logic [J_W-1:0]      out_group,
  output logic [J_W-1:0]      out_j,
  output logic                out_last
);

  localparam int unsigned        CNT_W      = J_W + 1;
  localparam logic [STAGE_W-1:0] LAST_STAGE = STAGE_W'(LOG2N - 1);

  state_t state_q, state_d;

  logic [STAGE_W-1:0] s_q;
  logic [J_W-1:0]     g_q;
  logic [J_W-1:0]     j_q;
  sb_t                sb_cur_q;
  sb_t                sb_out;

  logic               accept_c;
  logic               issue_c;
  logic               finish_c;
  logic [STAGE_W-1:0] shift_c;
  logic [CNT_W-1:0]   j_span_c;
  logic [CNT_W-1:0]   g_span_c;
  logic               j_wrap_c;
  logic               g_wrap_c;
  logic               last_c;

  // Loop bounds for the current stage: 2^s indices per group, 2^(LOG2N-1-s) groups
  always_comb begin
    shift_c  = LAST_STAGE - s_q;
    j_span_c = CNT_W'(1) << s_q;
    g_span_c = CNT_W'(1) << shift_c;
    j_wrap_c = ({1'b0, j_q} == (j_span_c - CNT_W'(1)));
    g_wrap_c = ({1'b0, g_q} == (g_span_c - CNT_W'(1)));
    last_c   = j_wrap_c && g_wrap_c && (s_q == LAST_STAGE);
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept_c) state_d = ISSUE;
      ISSUE:   if (issue_c && last_c) state_d = DRAIN;
      DRAIN:   if (finish_c) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A start landing on the done cycle is dropped so one request yields one sweep
  always_comb begin
    accept_c = 1'b0;
    issue_c  = 1'b0;
    finish_c = 1'b0;
    case (state_q)
      IDLE:    accept_c = start && ce && !done;
      ISSUE:   issue_c  = ce;
      DRAIN:   finish_c = ce && sb_out.valid && sb_out.last;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s_q      <= '0;
      g_q      <= '0;
      j_q      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      mul_din0 <= '0;
      mul_din1 <= '0;
      sb_cur_q <= '0;
    end else begin
      done <= finish_c;
      if (accept_c) begin
        s_q  <= '0;
        g_q  <= '0;
        j_q  <= '0;
        busy <= 1'b1;
      end
      if (finish_c) busy <= 1'b0;
      if (issue_c) begin
        mul_din0 <= j_q;
        mul_din1 <= STRIDE_W'(1) << shift_c;
        sb_cur_q <= '{valid: 1'b1, last: last_c, stage: s_q, group: g_q, j: j_q};
        if (j_wrap_c) begin
          j_q <= '0;
          if (g_wrap_c) begin
            g_q <= '0;
            s_q <= s_q + STAGE_W'(1);
          end else begin
            g_q <= g_q + J_W'(1);
          end
        end else begin
          j_q <= j_q + J_W'(1);
        end
      end else if (ce) begin
        // Operands hold; only a bubble enters the delay line
        sb_cur_q.valid <= 1'b0;
        sb_cur_q.last  <= 1'b0;
      end
    end
  end

  fwd_fft_sideband_dly #(
    .DEPTH(MUL_LAT)
  ) u_dly (
    .clk  (clk),
    .reset(reset),
    .ce   (ce),
    .din  (sb_cur_q),
    .dout (sb_out)
  );

  assign out_valid = sb_out.valid;
  assign out_last  = sb_out.last;
  assign out_stage = sb_out.stage;
  assign out_group = sb_out.group;
  assign out_j     = sb_out.j;

endmodule

// File: tb/tb_fwd_fft_bfly_idx_gen.sv
// Directed bench for the butterfly index generator: an 8-point instance with
// hand-computed tables and a 512-point instance checked against nested loops.
module tb_fwd_fft_bfly_idx_gen;
  import fwd_fft_idx_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  logic                reset3, ce3, start3, busy3, done3, ov3, ol3;
  logic [J_W-1:0]      d0_3, og3, oj3;
  logic [STRIDE_W-1:0] d1_3;
  logic [STAGE_W-1:0]  os3;

  logic                reset9, ce9, start9, busy9, done9, ov9, ol9;
  logic [J_W-1:0]      d0_9, og9, oj9;
  logic [STRIDE_W-1:0] d1_9;
  logic [STAGE_W-1:0]  os9;

  fwd_fft_bfly_idx_gen #(.LOG2N(3), .MUL_LAT(3)) dut3 (
    .clk(clk), .reset(reset3), .ce(ce3), .start(start3), .busy(busy3), .done(done3),
    .mul_din0(d0_3), .mul_din1(d1_3), .out_valid(ov3), .out_stage(os3),
    .out_group(og3), .out_j(oj3), .out_last(ol3)
  );

  fwd_fft_bfly_idx_gen #(.LOG2N(LOG2N_MAX), .MUL_LAT(3)) dut9 (
    .clk(clk), .reset(reset9), .ce(ce9), .start(start9), .busy(busy9), .done(done9),
    .mul_din0(d0_9), .mul_din1(d1_9), .out_valid(ov9), .out_stage(os9),
    .out_group(og9), .out_j(oj9), .out_last(ol9)
  );

  // Three-register ce-gated multiplier stand-in; keeps operands so they can be checked
  logic [J_W-1:0]      m0_3 [3];
  logic [STRIDE_W-1:0] m1_3 [3];
  logic [J_W-1:0]      m0_9 [3];
  logic [STRIDE_W-1:0] m1_9 [3];
  logic [PROD_W-1:0]   prod3, prod9;

  always @(posedge clk) begin
    if (ce3) begin
      m0_3[0] <= d0_3; m0_3[1] <= m0_3[0]; m0_3[2] <= m0_3[1];
      m1_3[0] <= d1_3; m1_3[1] <= m1_3[0]; m1_3[2] <= m1_3[1];
    end
    if (ce9) begin
      m0_9[0] <= d0_9; m0_9[1] <= m0_9[0]; m0_9[2] <= m0_9[1];
      m1_9[0] <= d1_9; m1_9[1] <= m1_9[0]; m1_9[2] <= m1_9[1];
    end
  end

  assign prod3 = PROD_W'(m0_3[2]) * PROD_W'(m1_3[2]);
  assign prod9 = PROD_W'(m0_9[2]) * PROD_W'(m1_9[2]);

  int exp_s  [12] = '{0, 0, 0, 0, 1, 1, 1, 1, 2, 2, 2, 2};
  int exp_g  [12] = '{0, 1, 2, 3, 0, 0, 1, 1, 0, 0, 0, 0};
  int exp_j  [12] = '{0, 0, 0, 0, 0, 1, 0, 1, 0, 1, 2, 3};
  int exp_st [12] = '{4, 4, 4, 4, 2, 2, 2, 2, 1, 1, 1, 1};
  int exp_k  [12] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};

  typedef struct {
    int s;
    int g;
    int j;
  } item_t;
  item_t q9[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One 8-point sweep; stall selects ce pattern 1,0,0,1; poke re-requests start mid-sweep and on done
  task automatic sweep3(input bit stall, input bit poke);
    int   n        = 0;
    int   dones    = 0;
    int   last_cyc = -1;
    int   done_cyc = -1;
    logic ce_v;
    logic st_v     = 1'b0;
    ce3    = 1'b1;
    start3 = 1'b1;
    tick();
    start3 = 1'b0;
    chk("start_busy", busy3, 1);
    for (int cyc = 0; cyc < 60; cyc++) begin
      ce_v   = !stall || (cyc % 4 == 0) || (cyc % 4 == 3);
      ce3    = ce_v;
      start3 = st_v || (poke && cyc == 5);
      tick();
      st_v = 1'b0;
      if (!ce_v && ov3 && n > 0 && n <= 12) begin
        chk("hold_out_j", oj3, exp_j[n-1]);
        chk("hold_k", prod3, exp_k[n-1]);
      end
      if (ce_v && ov3) begin
        chk("out_count_ok", n < 12, 1);
        if (n < 12) begin
          chk("din0", m0_3[2], exp_j[n]);
          chk("din1", m1_3[2], exp_st[n]);
          chk("k", prod3, exp_k[n]);
          chk("out_stage", os3, exp_s[n]);
          chk("out_group", og3, exp_g[n]);
          chk("out_j", oj3, exp_j[n]);
          chk("out_last", ol3, n == 11);
        end
        if (ol3) last_cyc = cyc;
        n++;
      end
      if (done3) begin
        dones++;
        done_cyc = cyc;
        st_v     = poke;
        chk("done_busy_low", busy3, 0);
      end
    end
    start3 = 1'b0;
    ce3    = 1'b1;
    chk("issue_count", n, 12);
    chk("done_count", dones, 1);
    chk("idle_after", busy3, 0);
    if (!stall) chk("done_latency", done_cyc - last_cyc, 1);
  endtask

  initial begin
    int n9, dones9, max_j, max_st, max_k, ek;
    reset3 = 1'b1; ce3 = 1'b1; start3 = 1'b0;
    reset9 = 1'b1; ce9 = 1'b1; start9 = 1'b0;
    repeat (4) tick();
    chk("rst_busy", busy3, 0);
    chk("rst_done", done3, 0);
    chk("rst_din0", d0_3, 0);
    chk("rst_din1", d1_3, 0);
    chk("rst_valid", ov3, 0);
    chk("rst_stage", os3, 0);
    chk("rst_group", og3, 0);
    chk("rst_j", oj3, 0);
    chk("rst_last", ol3, 0);
    chk("rst9_busy", busy9, 0);
    chk("rst9_valid", ov9, 0);
    reset3 = 1'b0;
    reset9 = 1'b0;
    tick();
    chk("idle_busy", busy3, 0);

    sweep3(1'b0, 1'b0);
    sweep3(1'b1, 1'b0);
    sweep3(1'b0, 1'b1);

    // Reset after the fifth issue, then a clean sweep
    start3 = 1'b1;
    tick();
    start3 = 1'b0;
    repeat (5) tick();
    chk("pre_rst_busy", busy3, 1);
    chk("pre_rst_din1", d1_3, 2);
    reset3 = 1'b1;
    tick();
    reset3 = 1'b0;
    chk("mid_rst_busy", busy3, 0);
    chk("mid_rst_valid", ov3, 0);
    chk("mid_rst_din0", d0_3, 0);
    chk("mid_rst_din1", d1_3, 0);
    chk("mid_rst_done", done3, 0);
    sweep3(1'b0, 1'b0);

    // start with ce low is neither accepted nor remembered
    ce3    = 1'b0;
    start3 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("ce0_start_busy", busy3, 0);
    end
    start3 = 1'b0;
    ce3    = 1'b1;
    repeat (2) tick();
    chk("ce0_release_busy", busy3, 0);
    chk("ce0_release_valid", ov3, 0);

    // 512-point reference order
    for (int s = 0; s < 9; s++)
      for (int g = 0; g < (1 << (8 - s)); g++)
        for (int j = 0; j < (1 << s); j++)
          q9.push_back('{s: s, g: g, j: j});
    n9 = 0; dones9 = 0; max_j = 0; max_st = 0; max_k = 0;
    start9 = 1'b1;
    tick();
    start9 = 1'b0;
    for (int cyc = 0; cyc < 2400; cyc++) begin
      tick();
      if (ov9) begin
        chk("n9_count_ok", n9 < 2304, 1);
        if (n9 < 2304) begin
          ek = q9[n9].j << (8 - q9[n9].s);
          chk("n9_stage", os9, q9[n9].s);
          chk("n9_group", og9, q9[n9].g);
          chk("n9_j", oj9, q9[n9].j);
          chk("n9_k", prod9, ek);
          chk("n9_last", ol9, n9 == 2303);
        end
        if (int'(m0_9[2]) > max_j) max_j = int'(m0_9[2]);
        if (int'(m1_9[2]) > max_st) max_st = int'(m1_9[2]);
        if (int'(prod9) > max_k) max_k = int'(prod9);
        n9++;
      end
      if (done9) dones9++;
    end
    chk("n9_total", n9, 2304);
    chk("n9_max_j", max_j, 255);
    chk("n9_max_stride", max_st, 256);
    chk("n9_max_k", max_k, 255);
    chk("n9_done_count", dones9, 1);
    chk("n9_idle", busy9, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
